// File: rtl/ssf_pkg.sv
// Shared types, widths, coefficients and arithmetic helpers for the
// sparse-signal filter (FIR + saturation + soft threshold).
package ssf_pkg;

   localparam int DW    = 32;              // sample / output width (signed)
   localparam int NTAPS = 7;               // number of FIR taps
   localparam int CW    = 16;              // coefficient width (signed)
   localparam int SHIFT = 8;               // coefficients are Q.SHIFT
   localparam int ACCW  = 64;              // accumulator width, never overflows
   localparam int PW    = DW + CW;         // full product width
   localparam int IDXW  = $clog2(NTAPS);   // tap index width

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_MAC,
      S_FIN,
      S_OUT
   } state_t;

   // Matched pulse shape; index 0 weights the newest sample.
   localparam logic signed [CW-1:0] COEF [NTAPS] = '{
      16'sd0, 16'sd19, 16'sd144, 16'sd256, 16'sd177, 16'sd64, 16'sd15
   };

   localparam logic [1:0] PULSE_ON  = 2'b01;
   localparam logic [1:0] PULSE_OFF = 2'b00;

   localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // Clamp a wide signed value into the DW-bit signed range.
   function automatic logic signed [DW-1:0] saturate(input logic signed [ACCW-1:0] v);
      logic signed [ACCW-1:0] c;
      if (v > SAT_MAX)      c = SAT_MAX;
      else if (v < SAT_MIN) c = SAT_MIN;
      else                  c = v;
      return c[DW-1:0];
   endfunction

   // Shrink towards zero by thr; values inside [-thr, thr] become 0.
   // One extra bit keeps -thr and the subtraction free of wrap-around.
   function automatic logic signed [DW-1:0] soft_threshold(input logic signed [DW-1:0] y,
                                                           input logic [DW-1:0] thr);
      logic signed [DW:0] ye;
      logic signed [DW:0] te;
      logic signed [DW:0] r;
      ye = {y[DW-1], y};
      te = {1'b0, thr};
      if (ye > te)       r = ye - te;
      else if (ye < -te) r = ye + te;
      else               r = '0;
      return r[DW-1:0];
   endfunction

endpackage

// File: rtl/ssf_mac.sv
// Sequential multiply-accumulate: one tap per enabled cycle, with its own
// tap-index counter so the caller only has to supply window[o_idx].
module ssf_mac
   import ssf_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clear,
   input  logic                   i_en,
   input  logic signed [DW-1:0]   i_sample,
   output logic [IDXW-1:0]        o_idx,
   output logic                   o_done,
   output logic signed [ACCW-1:0] o_acc
);

   logic [IDXW-1:0]        r_idx;
   logic signed [ACCW-1:0] r_acc;
   logic signed [CW-1:0]   w_coef_raw;
   logic signed [PW-1:0]   w_coef;
   logic signed [PW-1:0]   w_samp;
   logic signed [PW-1:0]   w_prod;
   logic                   w_last;

   assign w_coef_raw = COEF[r_idx];
   assign w_coef     = {{(PW-CW){w_coef_raw[CW-1]}}, w_coef_raw};
   assign w_samp     = {{(PW-DW){i_sample[DW-1]}}, i_sample};
   assign w_prod     = w_coef * w_samp;
   assign w_last     = (r_idx == IDXW'(NTAPS-1));

   assign o_idx  = r_idx;
   assign o_done = i_en & w_last;
   assign o_acc  = r_acc;

   // Accumulate COEF[k]*window[k]; clear restarts at tap 0 with acc = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
         r_idx <= w_last ? '0 : r_idx + IDXW'(1);
      end
   end

endmodule

// File: rtl/ssf_blackbox.sv
// Sample-serial sparse-signal filter: pulls one sample, runs an NTAPS-cycle
// MAC over the sample window, then shifts, saturates and soft-thresholds.
//
// Handshake: req_in == 2'b01 for exactly one cycle means `in` is consumed at
// the closing rising edge; the source may change `in` only after that edge.
// out_en == 2'b01 for exactly one cycle marks io_out as a fresh result;
// io_out holds its value otherwise. The two pulses never coincide.
module ssf_blackbox
   import ssf_pkg::*;
#(
   parameter logic [DW-1:0] THR = '0
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [DW-1:0] in,
   output logic signed [DW-1:0] io_out,
   output logic [1:0]           req_in,
   output logic [1:0]           out_en
);

   state_t                 r_state;
   logic signed [DW-1:0]   r_win [NTAPS];
   logic signed [DW-1:0]   r_out;
   logic [1:0]             r_req;
   logic [1:0]             r_oe;

   logic                   w_clear;
   logic                   w_en;
   logic [IDXW-1:0]        w_idx;
   logic                   w_done;
   logic signed [ACCW-1:0] w_acc;
   logic signed [ACCW-1:0] w_shifted;
   logic signed [DW-1:0]   w_sample;
   logic signed [DW-1:0]   w_y;

   assign w_clear   = (r_state == S_REQ);
   assign w_en      = (r_state == S_MAC);
   assign w_sample  = r_win[w_idx];
   assign w_shifted = w_acc >>> SHIFT;
   assign w_y       = soft_threshold(saturate(w_shifted), THR);

   assign io_out = r_out;
   assign req_in = r_req;
   assign out_en = r_oe;

   ssf_mac u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (w_clear),
      .i_en     (w_en),
      .i_sample (w_sample),
      .o_idx    (w_idx),
      .o_done   (w_done),
      .o_acc    (w_acc)
   );

   // Sample window: newest sample enters slot 0 at the REQ edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NTAPS; k++) r_win[k] <= '0;
      end else if (r_state == S_REQ) begin
         for (int k = NTAPS-1; k > 0; k--) r_win[k] <= r_win[k-1];
         r_win[0] <= in;
      end
   end

   // Control FSM with registered request/strobe pulses and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_req   <= PULSE_OFF;
         r_oe    <= PULSE_OFF;
         r_out   <= '0;
      end else begin
         r_req <= PULSE_OFF;
         r_oe  <= PULSE_OFF;
         case (r_state)
            S_IDLE: begin
               r_state <= S_REQ;
               r_req   <= PULSE_ON;
            end
            S_REQ: begin
               r_state <= S_MAC;
            end
            S_MAC: begin
               if (w_done) r_state <= S_FIN;
            end
            S_FIN: begin
               r_out   <= w_y;
               r_oe    <= PULSE_ON;
               r_state <= S_OUT;
            end
            S_OUT: begin
               r_state <= S_REQ;
               r_req   <= PULSE_ON;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ssf_blackbox.sv
// Bench for ssf_blackbox: two instances (THR=0 and THR=100) share clock,
// reset and source; a queue-based FIR model predicts every output.
module tb_ssf_blackbox;

   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic                clk   = 1'b0;
   logic                rst_n = 1'b0;
   logic signed [31:0]  in_s  = '0;
   logic signed [31:0]  out0, out1;
   logic [1:0]          req0, req1, oe0, oe1;

   int  n_checks  = 0;
   int  n_fail    = 0;
   int  n_edges   = 0;
   int  out_count = 0;
   bit  req_seen  = 0;
   bit  is_req, is_oe;

   logic signed [31:0] stim_q[$];
   logic signed [31:0] hist[$];
   logic signed [31:0] exp_q0[$];
   logic signed [31:0] exp_q1[$];
   logic signed [31:0] got0_q[$];
   logic signed [31:0] got1_q[$];
   logic signed [31:0] last0 = '0;
   logic signed [31:0] last1 = '0;

   int     coef_m [7] = '{0, 19, 144, 256, 177, 64, 15};
   longint imp0   [10] = '{0, 74, 562, 1000, 691, 250, 58, 0, 0, 0};
   longint imp1   [10] = '{0, 0, 462, 900, 591, 150, 0, 0, 0, 0};
   longint neg0   [8]  = '{0, -75, -563, -1000, -692, -250, -59, 0};
   longint neg1   [8]  = '{0, 0, -463, -900, -592, -150, 0, 0};

   // clock / reset block
   always #5 clk = ~clk;

   ssf_blackbox #(.THR(32'd0)) u_dut0 (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in_s),
      .io_out (out0),
      .req_in (req0),
      .out_en (oe0)
   );

   ssf_blackbox #(.THR(32'd100)) u_dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (in_s),
      .io_out (out1),
      .req_in (req1),
      .out_en (oe1)
   );

   task automatic check(input string tag, input longint obs, input longint exp_v);
      n_checks++;
      if (obs != exp_v) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference: y = floor(sum coef[k]*x[n-k] / 2^8), clamp, then soft threshold.
   function automatic logic signed [31:0] model_y(input longint thr);
      longint acc;
      longint y;
      acc = 0;
      for (int k = 0; k < hist.size(); k++)
         acc += longint'(coef_m[k]) * longint'(hist[k]);
      y = acc >>> 8;
      if (y > MAXV)      y = MAXV;
      else if (y < MINV) y = MINV;
      if (y > thr)       y = y - thr;
      else if (y < -thr) y = y + thr;
      else               y = 0;
      return y[31:0];
   endfunction

   // edge counter since reset release
   always @(posedge clk) begin
      if (!rst_n) n_edges = 0;
      else        n_edges++;
   end

   // source driver: model consumes the sample at the requested edge
   always @(posedge clk) begin
      if (rst_n && req_seen) begin
         hist.push_front(in_s);
         if (hist.size() > 7) void'(hist.pop_back());
         exp_q0.push_back(model_y(0));
         exp_q1.push_back(model_y(100));
         #1;
         if (stim_q.size() > 0) in_s = stim_q.pop_front();
         else                   in_s = '0;
      end
   end

   // monitor / scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         req_seen = 0;
         check("rst_io_out0", out0, 0);
         check("rst_io_out1", out1, 0);
         check("rst_req_in",  req0, 0);
         check("rst_out_en",  oe0,  0);
      end else begin
         is_req   = (n_edges % 10 == 1);
         is_oe    = (n_edges % 10 == 0) && (n_edges > 0);
         req_seen = (req0 == 2'b01);
         check("req_in0", req0, is_req ? 1 : 0);
         check("req_in1", req1, is_req ? 1 : 0);
         check("out_en0", oe0,  is_oe  ? 1 : 0);
         check("out_en1", oe1,  is_oe  ? 1 : 0);
         if (is_oe) begin
            check("exp_avail", exp_q0.size(), 1);
            if (exp_q0.size() > 0) begin
               last0 = exp_q0.pop_front();
               last1 = exp_q1.pop_front();
            end
            got0_q.push_back(out0);
            got1_q.push_back(out1);
            out_count++;
         end
         check("io_out0", out0, last0);
         check("io_out1", out1, last1);
      end
   end

   // driver tasks
   task automatic apply_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      hist.delete();
      exp_q0.delete();
      exp_q1.delete();
      got0_q.delete();
      got1_q.delete();
      last0     = '0;
      last1     = '0;
      out_count = 0;
      if (stim_q.size() > 0) in_s = stim_q.pop_front();
      else                   in_s = '0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic run_segment(input int n_out);
      apply_reset();
      for (int c = 0; c < n_out * 10 + 30; c++) begin
         @(negedge clk);
         #1;
         if (out_count >= n_out) break;
      end
      check("seg_outputs", out_count, n_out);
   endtask

   initial begin
      // impulse
      stim_q.delete();
      stim_q.push_back(32'sd1000);
      run_segment(10);
      for (int i = 0; i < 10; i++) begin
         check("imp_y0", got0_q[i], imp0[i]);
         check("imp_y1", got1_q[i], imp1[i]);
      end

      // negative impulse
      stim_q.delete();
      stim_q.push_back(-32'sd1000);
      run_segment(8);
      for (int i = 0; i < 8; i++) begin
         check("neg_y0", got0_q[i], neg0[i]);
         check("neg_y1", got1_q[i], neg1[i]);
      end

      // positive saturation
      stim_q.delete();
      for (int i = 0; i < 10; i++) stim_q.push_back(32'h7fff_ffff);
      run_segment(10);
      for (int i = 6; i < 10; i++) begin
         check("sat_pos0", got0_q[i], 64'sd2147483647);
         check("sat_pos1", got1_q[i], 64'sd2147483547);
      end

      // negative saturation
      stim_q.delete();
      for (int i = 0; i < 10; i++) stim_q.push_back(32'h8000_0000);
      run_segment(10);
      for (int i = 6; i < 10; i++) begin
         check("sat_neg0", got0_q[i], -64'sd2147483648);
         check("sat_neg1", got1_q[i], -64'sd2147483548);
      end

      // random mix of full-range and small samples
      stim_q.delete();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) stim_q.push_back($urandom);
         else stim_q.push_back(int'($urandom_range(0, 4000)) - 2000);
      end
      run_segment(40);

      // reset during MAC of the third sample
      stim_q.delete();
      for (int i = 0; i < 3; i++) stim_q.push_back(int'($urandom_range(0, 20000)) - 10000);
      apply_reset();
      repeat (24) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_io_out0", out0, 0);
      check("midrst_out_en0", oe0, 0);
      check("midrst_outputs", out_count, 2);

      // clean impulse after the abort
      stim_q.delete();
      stim_q.push_back(32'sd1000);
      run_segment(10);
      for (int i = 0; i < 10; i++) begin
         check("post_rst_imp0", got0_q[i], imp0[i]);
         check("post_rst_imp1", got1_q[i], imp1[i]);
      end

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
